// File: rtl/text_console_ctrl_if.sv
// Byte stream from the CPU and write port toward the text video memory.
// The master is the CPU/video-memory side and the slave is the console sequencer.
interface text_console_ctrl_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic              video_write_enable;
  logic [7:0]        video_write_data;
  logic [ADDR_W-1:0] video_write_addr;

  modport master (
    output char_valid,
    output char_data,
    input  char_ready,
    input  video_write_enable,
    input  video_write_data,
    input  video_write_addr
  );

  modport slave (
    input  char_valid,
    input  char_data,
    output char_ready,
    output video_write_enable,
    output video_write_data,
    output video_write_addr
  );
endinterface

// File: rtl/text_console_ctrl.sv
// Cursor/control-code sequencer that owns the text video memory write port.
// Optional macro CONSOLE_CURSOR_EN keeps an '_' glyph drawn at the cursor cell.
module text_console_ctrl #(
  parameter int unsigned COLS   = 50,
  parameter int unsigned ROWS   = 24,
  parameter int unsigned ADDR_W = 11,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic               CLK_CPU,
  input  logic               reset,
  text_console_ctrl_if.slave bus,
  output logic [5:0]         cursor_col,
  output logic [4:0]         cursor_row,
  output logic               busy
);

  localparam int unsigned COL_W = 6;
  localparam int unsigned ROW_W = 5;
  localparam int unsigned CELLS = ROWS * COLS;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PUT     = 3'd1;
  localparam logic [2:0] S_CLR_ROW = 3'd2;
  localparam logic [2:0] S_CLR_ALL = 3'd3;
`ifdef CONSOLE_CURSOR_EN
  localparam logic [2:0] S_CURS    = 3'd4;
  localparam logic [2:0] S_UNCURS  = 3'd5;
  localparam logic [7:0] CURSOR_GLYPH = 8'h5F;
`endif

  logic [2:0]        r_state;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [ADDR_W-1:0] r_base;
  logic              r_we;
  logic [7:0]        r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_ready;
  logic              r_busy;
  logic [COL_W-1:0]  r_cnt;
  logic              r_wrap;
`ifdef CONSOLE_CURSOR_EN
  logic [7:0]        r_op;
  logic              r_curs;
  logic [7:0]        w_op_nxt;
  logic              w_curs_nxt;
`endif

  logic [2:0]        w_state_nxt;
  logic [COL_W-1:0]  w_col_nxt;
  logic [ROW_W-1:0]  w_row_nxt;
  logic [ADDR_W-1:0] w_base_nxt;
  logic              w_we_nxt;
  logic [7:0]        w_data_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_ready_nxt;
  logic              w_busy_nxt;
  logic [COL_W-1:0]  w_cnt_nxt;
  logic              w_wrap_nxt;

  logic              w_take;
  logic              w_printable;
  logic              w_is_lf;
  logic              w_is_cr;
  logic              w_is_ff;
  logic              w_bs_move;
  logic              w_last_row;
  logic              w_last_col;
  logic [ROW_W-1:0]  w_row_up;
  logic [ADDR_W-1:0] w_base_up;
  logic [ADDR_W-1:0] w_cell;

  // Byte decode and row arithmetic; row_base moves by +-COLS so no multiplier is needed.
  assign w_take      = bus.char_valid && r_ready;
  assign w_printable = (bus.char_data >= 8'h20) && (bus.char_data <= 8'h7E);
  assign w_is_lf     = (bus.char_data == CH_LF);
  assign w_is_cr     = (bus.char_data == CH_CR);
  assign w_is_ff     = (bus.char_data == CH_FF);
  assign w_bs_move   = (bus.char_data == CH_BS) && (r_col != '0);
  assign w_last_row  = (r_row == ROW_W'(ROWS - 1));
  assign w_last_col  = (r_col == COL_W'(COLS - 1));
  assign w_row_up    = w_last_row ? '0 : ROW_W'(r_row + ROW_W'(1));
  assign w_base_up   = w_last_row ? '0 : ADDR_W'(r_base + ADDR_W'(COLS));
  assign w_cell      = ADDR_W'(r_base + ADDR_W'(r_col));

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_base_nxt  = r_base;
    w_we_nxt    = 1'b0;
    w_data_nxt  = r_data;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_wrap_nxt  = r_wrap;
`ifdef CONSOLE_CURSOR_EN
    w_op_nxt    = r_op;
    w_curs_nxt  = r_curs;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_state_nxt = S_PUT;
          w_wrap_nxt  = 1'b0;
`ifdef CONSOLE_CURSOR_EN
          w_curs_nxt  = 1'b0;
`endif
          if (w_printable) begin
            w_we_nxt   = 1'b1;
            w_data_nxt = bus.char_data;
            w_addr_nxt = w_cell;
            if (w_last_col) begin
              w_col_nxt  = '0;
              w_row_nxt  = w_row_up;
              w_base_nxt = w_base_up;
              w_wrap_nxt = w_last_row;
            end else begin
              w_col_nxt = COL_W'(r_col + COL_W'(1));
            end
`ifdef CONSOLE_CURSOR_EN
            w_curs_nxt = 1'b1;
`endif
          end else if (w_is_ff) begin
            w_state_nxt = S_CLR_ALL;
            w_we_nxt    = 1'b1;
            w_data_nxt  = BLANK;
            w_addr_nxt  = '0;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
            w_base_nxt  = '0;
`ifdef CONSOLE_CURSOR_EN
          end else if (w_is_lf || w_is_cr || w_bs_move) begin
            // Erase the drawn cursor first; the move itself happens in UNCURS.
            w_state_nxt = S_UNCURS;
            w_we_nxt    = 1'b1;
            w_data_nxt  = BLANK;
            w_addr_nxt  = w_cell;
            w_op_nxt    = bus.char_data;
          end
`else
          end else if (w_is_lf) begin
            w_col_nxt  = '0;
            w_row_nxt  = w_row_up;
            w_base_nxt = w_base_up;
            w_wrap_nxt = w_last_row;
          end else if (w_is_cr) begin
            w_col_nxt = '0;
          end else if (w_bs_move) begin
            w_col_nxt  = COL_W'(r_col - COL_W'(1));
            w_we_nxt   = 1'b1;
            w_data_nxt = BLANK;
            w_addr_nxt = ADDR_W'(w_cell - ADDR_W'(1));
          end
`endif
        end
      end

      S_PUT: begin
        if (r_wrap) begin
          w_state_nxt = S_CLR_ROW;
          w_we_nxt    = 1'b1;
          w_data_nxt  = BLANK;
          w_addr_nxt  = r_base;
          w_cnt_nxt   = '0;
          w_wrap_nxt  = 1'b0;
        end
`ifdef CONSOLE_CURSOR_EN
        else if (r_curs) begin
          w_state_nxt = S_CURS;
          w_we_nxt    = 1'b1;
          w_data_nxt  = CURSOR_GLYPH;
          w_addr_nxt  = w_cell;
          w_curs_nxt  = 1'b0;
        end
`endif
        else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_CLR_ROW: begin
        if (r_cnt == COL_W'(COLS - 1)) begin
`ifdef CONSOLE_CURSOR_EN
          w_state_nxt = S_CURS;
          w_we_nxt    = 1'b1;
          w_data_nxt  = CURSOR_GLYPH;
          w_addr_nxt  = w_cell;
`else
          w_state_nxt = S_IDLE;
`endif
        end else begin
          w_cnt_nxt  = COL_W'(r_cnt + COL_W'(1));
          w_we_nxt   = 1'b1;
          w_data_nxt = BLANK;
          w_addr_nxt = ADDR_W'(r_addr + ADDR_W'(1));
        end
      end

      S_CLR_ALL: begin
        // Entered from reset with no write pending: the first cycle launches address 0.
        if (!r_we) begin
          w_we_nxt   = 1'b1;
          w_data_nxt = BLANK;
          w_addr_nxt = '0;
          w_col_nxt  = '0;
          w_row_nxt  = '0;
          w_base_nxt = '0;
        end else if (r_addr == ADDR_W'(CELLS - 1)) begin
`ifdef CONSOLE_CURSOR_EN
          w_state_nxt = S_CURS;
          w_we_nxt    = 1'b1;
          w_data_nxt  = CURSOR_GLYPH;
          w_addr_nxt  = w_cell;
`else
          w_state_nxt = S_IDLE;
`endif
        end else begin
          w_we_nxt   = 1'b1;
          w_data_nxt = BLANK;
          w_addr_nxt = ADDR_W'(r_addr + ADDR_W'(1));
        end
      end

`ifdef CONSOLE_CURSOR_EN
      S_UNCURS: begin
        if (r_op == CH_LF) begin
          w_col_nxt  = '0;
          w_row_nxt  = w_row_up;
          w_base_nxt = w_base_up;
          if (w_last_row) begin
            w_state_nxt = S_CLR_ROW;
            w_we_nxt    = 1'b1;
            w_data_nxt  = BLANK;
            w_addr_nxt  = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_CURS;
            w_we_nxt    = 1'b1;
            w_data_nxt  = CURSOR_GLYPH;
            w_addr_nxt  = w_base_up;
          end
        end else if (r_op == CH_CR) begin
          w_col_nxt   = '0;
          w_state_nxt = S_CURS;
          w_we_nxt    = 1'b1;
          w_data_nxt  = CURSOR_GLYPH;
          w_addr_nxt  = r_base;
        end else begin
          w_col_nxt   = COL_W'(r_col - COL_W'(1));
          w_state_nxt = S_PUT;
          w_we_nxt    = 1'b1;
          w_data_nxt  = BLANK;
          w_addr_nxt  = ADDR_W'(w_cell - ADDR_W'(1));
          w_curs_nxt  = 1'b1;
        end
      end

      S_CURS: begin
        w_state_nxt = S_IDLE;
      end
`endif

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt  = !w_ready_nxt;
  end

  always_ff @(posedge CLK_CPU) begin
    if (!reset) begin
      r_state <= S_CLR_ALL;
      r_col   <= '0;
      r_row   <= '0;
      r_base  <= '0;
      r_we    <= 1'b0;
      r_data  <= '0;
      r_addr  <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
`ifdef CONSOLE_CURSOR_EN
      r_op    <= '0;
      r_curs  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_base  <= w_base_nxt;
      r_we    <= w_we_nxt;
      r_data  <= w_data_nxt;
      r_addr  <= w_addr_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wrap  <= w_wrap_nxt;
`ifdef CONSOLE_CURSOR_EN
      r_op    <= w_op_nxt;
      r_curs  <= w_curs_nxt;
`endif
    end
  end

  assign bus.char_ready         = r_ready;
  assign bus.video_write_enable = r_we;
  assign bus.video_write_data   = r_data;
  assign bus.video_write_addr   = r_addr;
  assign cursor_col             = r_col;
  assign cursor_row             = r_row;
  assign busy                   = r_busy;

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl: clears, printing, wrap, control codes and reset abort.
module tb_text_console_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] cursor_col;
  logic [4:0] cursor_row;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [18:0] wq[$];

  text_console_ctrl_if #(.ADDR_W(11)) bus_if ();

  text_console_ctrl #(
    .COLS(50), .ROWS(24), .ADDR_W(11), .BLANK(8'h20)
  ) dut (
    .CLK_CPU    (clk),
    .reset      (reset),
    .bus        (bus_if),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and log any write seen there.
  task automatic tick();
    @(negedge clk);
    if (bus_if.video_write_enable === 1'b1)
      wq.push_back({bus_if.video_write_addr, bus_if.video_write_data});
  endtask

  task automatic send(input logic [7:0] b);
    bus_if.char_valid = 1'b1;
    bus_if.char_data  = b;
    tick();
    bus_if.char_valid = 1'b0;
  endtask

  task automatic wait_ready(input int budget);
    int k = 0;
    while (bus_if.char_ready !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk("wait_ready", 32'(bus_if.char_ready), 32'd1);
  endtask

  task automatic send_wait(input logic [7:0] b);
    send(b);
    wait_ready(100);
  endtask

  task automatic chk_cursor(input string tag, input int col, input int row);
    chk({tag, "_col"}, 32'(cursor_col), 32'(col));
    chk({tag, "_row"}, 32'(cursor_row), 32'(row));
  endtask

  task automatic chk_clear(input string tag, input int n, input int base);
    int bad = 0;
    logic [18:0] e;
    chk({tag, "_count"}, 32'(wq.size()), 32'(n));
    for (int i = 0; i < wq.size(); i++) begin
      e = {11'(base + i), 8'h20};
      if (wq[i] !== e) bad++;
    end
    chk({tag, "_seq_bad"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int k;
    reset = 1'b0;
    bus_if.char_valid = 1'b0;
    bus_if.char_data  = 8'h00;

    // Reset held for three cycles.
    repeat (3) tick();
    chk("rst_we",    32'(bus_if.video_write_enable), 32'd0);
    chk("rst_data",  32'(bus_if.video_write_data),   32'd0);
    chk("rst_addr",  32'(bus_if.video_write_addr),   32'd0);
    chk("rst_ready", 32'(bus_if.char_ready),         32'd0);
    chk_cursor("rst", 0, 0);

    // Release: full-screen clear of 1200 cells.
    reset = 1'b1;
    wq.delete();
    wait_ready(1500);
    chk_clear("clr_all", 1200, 0);
    chk_cursor("clr_all", 0, 0);
    chk("idle_busy", 32'(busy), 32'd0);

    // 'A' at (0,0): write one cycle after acceptance.
    wq.delete();
    send(8'h41);
    chk("A_we",    32'(bus_if.video_write_enable), 32'd1);
    chk("A_data",  32'(bus_if.video_write_data),   32'h41);
    chk("A_addr",  32'(bus_if.video_write_addr),   32'd0);
    chk("A_ready", 32'(bus_if.char_ready),         32'd0);
    chk("A_busy",  32'(busy),                      32'd1);
    chk_cursor("A", 1, 0);
    tick();
    chk("A_ready_after", 32'(bus_if.char_ready),         32'd1);
    chk("A_we_after",    32'(bus_if.video_write_enable), 32'd0);

    // Move to (49,3): CR, three LFs, 49 printables.
    send_wait(8'h0D);
    chk_cursor("cr", 0, 0);
    for (int i = 0; i < 3; i++) send_wait(8'h0A);
    chk_cursor("lf3", 0, 3);
    for (int i = 0; i < 49; i++) send_wait(8'h2E);
    chk_cursor("at49", 49, 3);

    // 'Z' at the last column wraps to the next row.
    send(8'h5A);
    chk("Z_we",   32'(bus_if.video_write_enable), 32'd1);
    chk("Z_data", 32'(bus_if.video_write_data),   32'h5A);
    chk("Z_addr", 32'(bus_if.video_write_addr),   32'd199);
    chk_cursor("Z", 0, 4);
    wait_ready(10);

    // Backspace at column 0 is a no-op.
    send_wait(8'h0A);
    wq.delete();
    send(8'h08);
    chk("bs0_we", 32'(bus_if.video_write_enable), 32'd0);
    chk_cursor("bs0", 0, 5);
    wait_ready(10);
    chk("bs0_writes", 32'(wq.size()), 32'd0);

    // Backspace at (7,5) blanks (6,5) = addr 256.
    for (int i = 0; i < 7; i++) send_wait(8'h31);
    chk_cursor("at7", 7, 5);
    send(8'h08);
    chk("bs_we",   32'(bus_if.video_write_enable), 32'd1);
    chk("bs_data", 32'(bus_if.video_write_data),   32'h20);
    chk("bs_addr", 32'(bus_if.video_write_addr),   32'd256);
    chk_cursor("bs", 6, 5);
    wait_ready(10);

    // CR: one busy cycle, no write.
    wq.delete();
    send(8'h0D);
    chk("cr_ready", 32'(bus_if.char_ready), 32'd0);
    chk_cursor("cr5", 0, 5);
    tick();
    chk("cr_ready_next", 32'(bus_if.char_ready), 32'd1);

    // Unlisted byte is dropped.
    send(8'h7F);
    chk("del_busy", 32'(busy), 32'd1);
    tick();
    chk("del_ready", 32'(bus_if.char_ready), 32'd1);
    chk("drop_writes", 32'(wq.size()), 32'd0);
    chk_cursor("del", 0, 5);

    // Valid held through the busy cycle: still one byte consumed.
    bus_if.char_valid = 1'b1;
    bus_if.char_data  = 8'h42;
    tick();
    tick();
    bus_if.char_valid = 1'b0;
    wait_ready(10);
    chk("hold_writes", 32'(wq.size()), 32'd1);
    chk_cursor("hold", 1, 5);

    // LF from row 23 wraps to row 0 and clears only that row.
    for (int i = 0; i < 18; i++) send_wait(8'h0A);
    chk_cursor("row23", 0, 23);
    wq.delete();
    send(8'h0A);
    chk_cursor("lf_wrap", 0, 0);
    wait_ready(100);
    chk_clear("clr_row", 50, 0);
    chk_cursor("clr_row", 0, 0);

    // Form feed clears the whole screen.
    send_wait(8'h41);
    send_wait(8'h0A);
    wq.delete();
    send(8'h0C);
    wait_ready(1500);
    chk_clear("ff", 1200, 0);
    chk_cursor("ff", 0, 0);

    // Reset in the middle of a clear aborts and restarts it.
    wq.delete();
    send(8'h0C);
    k = 0;
    while (wq.size() < 300 && k < 1000) begin
      tick();
      k++;
    end
    chk("mid_reached", 32'(wq.size()), 32'd300);
    reset = 1'b0;
    tick();
    chk("mid_rst_we",    32'(bus_if.video_write_enable), 32'd0);
    chk("mid_rst_addr",  32'(bus_if.video_write_addr),   32'd0);
    chk("mid_rst_data",  32'(bus_if.video_write_data),   32'd0);
    chk("mid_rst_ready", 32'(bus_if.char_ready),         32'd0);
    chk_cursor("mid_rst", 0, 0);
    tick();
    reset = 1'b1;
    wq.delete();
    wait_ready(1500);
    chk_clear("restart", 1200, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
Sequencer that owns the write port of the 1536x8 text video memory and turns a byte stream from the CPU into character-cell writes. It tracks a cursor, interprets a few control codes, clears the screen and wraps rows. It sits in the CPU clock domain between the CPU I/O register and the video memory write port (video_write_enable/data/addr). The display engine reads the same memory independently.

Parameters:
COLS, 50, characters per text row (fixed by display timing)
ROWS, 24, text rows on screen
ADDR_W, 11, video memory address width
BLANK, 8'h20, glyph used for clearing

Ports:
CLK_CPU  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-low reset
char_valid  input  1  CPU offers a byte
char_data  input  8  byte offered (ASCII)
char_ready  output  1  block can accept a byte this cycle
video_write_enable  output  1  write strobe to video memory
video_write_data  output  8  glyph written
video_write_addr  output  ADDR_W  cell address = row*COLS + col
cursor_col  output  6  current column, 0..COLS-1
cursor_row  output  5  current row, 0..ROWS-1
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset==0 at an edge): video_write_enable=0, video_write_data=0, video_write_addr=0, char_ready=0, cursor_col=0, cursor_row=0. On release, the FSM enters CLR_ALL. Reset asserted at any time aborts the current operation and restarts from this state.
- Addressing: keep a row_base register (row*COLS) and update it by adding or subtracting COLS. No multiplier. addr = row_base + col, truncated to ADDR_W.
- FSM states: IDLE, PUT, CLR_ROW, CLR_ALL.
- IDLE: char_ready=1, busy=0, video_write_enable=0. A transfer happens when char_valid&&char_ready. Exactly one byte is consumed per transfer.
- Printable byte (0x20..0x7E), accepted in cycle N: in cycle N+1 (state PUT), video_write_enable=1, data=byte, addr=cursor cell. Then col++. If col reaches COLS: col=0 and row++.
- 0x0A LF: col=0, row++. No write.
- 0x0D CR: col=0. No write. Return to IDLE next cycle.
- 0x08 BS: if col>0, col-- and write BLANK at the new col (one PUT cycle). At col 0 it is a no-op; it never moves to the previous row.
- 0x0C FF: enter CLR_ALL.
- All other bytes (<0x20 not listed above, 0x7F..0xFF): accepted and dropped. One busy cycle, no write.
- Row advance past ROWS-1: row=0, row_base=0, then CLR_ROW clears row 0.
- CLR_ROW: COLS consecutive write cycles of BLANK at row_base+0 .. row_base+COLS-1. Cursor stays at col 0 of that row. Then IDLE.
- CLR_ALL: ROWS*COLS consecutive write cycles of BLANK at addresses 0 .. ROWS*COLS-1 (1200 with defaults). Cursor ends at (0,0). Then IDLE.
- char_ready is 0 in every non-IDLE state. char_valid held high during busy is not consumed. The CPU holds the byte until a transfer occurs.
- Addresses never exceed ROWS*COLS-1; memory cells 1200..1535 are never written.
- cursor_col/cursor_row update in the same cycle as the corresponding write.

Optional Feature:
Macro CONSOLE_CURSOR_EN.
- Defined: the cursor cell always shows 8'h5F '_'. After any operation that leaves the cursor at a new cell, one extra write cycle (state CURS) writes 0x5F there. LF/CR/wrap first write BLANK over the old cursor cell (state UNCURS), then proceed.
- Defined, clears: CLR_ALL and CLR_ROW finish with the CURS write.
- Not defined: states CURS/UNCURS are absent and cells are never written except as listed in Behaviour.

Test Plan:
- Reset low 3 cycles, release -> exactly 1200 writes of 0x20, addr 0..1199 ascending; then char_ready=1, cursor (0,0).
- Send 'A' (0x41) at (0,0) -> one cycle later we=1, data=0x41, addr=0; cursor (1,0); char_ready high again the following cycle.
- Place cursor at (49,3), send 'Z' -> write at addr 199; cursor (0,4).
- Cursor row 23, send 0x0A -> cursor (0,0), 50 writes of 0x20 at addr 0..49, no other writes.
- Cursor (0,5), send 0x08 -> no write, cursor unchanged. Cursor (7,5), send 0x08 -> write 0x20 at addr 256, cursor (6,5).
- Assert reset mid CLR_ALL (after 300 writes) -> outputs return to reset values next edge; on release the clear restarts at addr 0. With CONSOLE_CURSOR_EN, after 'A' at (0,0) -> writes 0x41@0 then 0x5F@1.
